// File: rtl/button_code_capture.sv
// button_code_capture
//   Turns one-cycle button edge pulses into key indices and packs DIGITS
//   presses into an entry code for the lock comparator.  Multi-button
//   presses abort the entry with a one-cycle entryError strobe.
//   Optional feature macro: INACTIVITY_TIMEOUT_EN -- discards a partial
//   entry after TIMEOUT_CYCLES idle cycles and pulses entryTimeout.
//   All outputs are registered; reset is synchronous, active-high.
module button_code_capture #(
    parameter int WIDTH          = 4,
    parameter int INDEX_WIDTH    = 2,
    parameter int DIGITS         = 4,
    parameter int COUNT_WIDTH    = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [WIDTH-1:0]                buttonEdge,
    output logic [DIGITS*INDEX_WIDTH-1:0]   code,
    output logic                            codeValid,
    output logic [COUNT_WIDTH-1:0]          digitCount,
    output logic                            entryError,
    output logic                            entryTimeout
);

    localparam int CODE_W = DIGITS * INDEX_WIDTH;

    // Elaboration-time guard against parameter sets that cannot work.
    if ((2**INDEX_WIDTH < WIDTH) || (2**COUNT_WIDTH <= DIGITS) ||
        (DIGITS < 1) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("button_code_capture: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                   state, state_n;
    logic [CODE_W-1:0]        code_n;
    logic [COUNT_WIDTH-1:0]   count_n;
    logic                     valid_n, error_n, timeout_n;
    logic                     single_press, multi_press;
    logic [INDEX_WIDTH-1:0]   press_index;

    // Position of the (single) set bit of a one-hot edge vector.
    function automatic logic [INDEX_WIDTH-1:0] encode_index(input logic [WIDTH-1:0] e);
        encode_index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (e[i]) encode_index = INDEX_WIDTH'(i);
        end
    endfunction

    // Classify the incoming edge vector: none, exactly one, or several buttons.
    always_comb begin
        single_press = (buttonEdge != '0) && ((buttonEdge & (buttonEdge - 1'b1)) == '0);
        multi_press  = (buttonEdge != '0) && !single_press;
        press_index  = encode_index(buttonEdge);
    end

`ifdef INACTIVITY_TIMEOUT_EN
    localparam int                TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    logic [TMR_W-1:0]             idle_tmr, idle_tmr_n;
`endif

    // Next-state and next-output logic; registered outputs follow one edge later.
    always_comb begin
        state_n   = state;
        code_n    = code;
        count_n   = digitCount;
        valid_n   = 1'b0;
        error_n   = 1'b0;
        timeout_n = 1'b0;
`ifdef INACTIVITY_TIMEOUT_EN
        idle_tmr_n = '0;
`endif
        if (multi_press) begin
            state_n = IDLE;
            code_n  = '0;
            count_n = '0;
            error_n = 1'b1;
        end else if (single_press) begin
            if (state == ENTRY) begin
                code_n = (code << INDEX_WIDTH) | CODE_W'(press_index);
                if (digitCount == COUNT_WIDTH'(DIGITS - 1)) begin
                    state_n = DONE;
                    count_n = '0;
                    valid_n = 1'b1;
                end else begin
                    count_n = digitCount + COUNT_WIDTH'(1);
                end
            end else begin
                // First digit: the previous (completed) code is dropped here.
                code_n = CODE_W'(press_index);
                if (DIGITS == 1) begin
                    state_n = DONE;
                    count_n = '0;
                    valid_n = 1'b1;
                end else begin
                    state_n = ENTRY;
                    count_n = COUNT_WIDTH'(1);
                end
            end
        end else begin
            if (state == DONE) begin
                state_n = IDLE;
            end
`ifdef INACTIVITY_TIMEOUT_EN
            if (state == ENTRY) begin
                if (idle_tmr == TMR_LAST) begin
                    state_n   = IDLE;
                    code_n    = '0;
                    count_n   = '0;
                    timeout_n = 1'b1;
                end else begin
                    idle_tmr_n = idle_tmr + TMR_W'(1);
                end
            end
`endif
        end
    end

    // State and output registers; reset discards any partial entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            code         <= '0;
            digitCount   <= '0;
            codeValid    <= 1'b0;
            entryError   <= 1'b0;
            entryTimeout <= 1'b0;
`ifdef INACTIVITY_TIMEOUT_EN
            idle_tmr     <= '0;
`endif
        end else begin
            state        <= state_n;
            code         <= code_n;
            digitCount   <= count_n;
            codeValid    <= valid_n;
            entryError   <= error_n;
            entryTimeout <= timeout_n;
`ifdef INACTIVITY_TIMEOUT_EN
            idle_tmr     <= idle_tmr_n;
`endif
        end
    end

endmodule

// File: tb/tb_button_code_capture.sv
// Testbench for button_code_capture: directed scenarios followed by random
// edge traffic, every cycle compared against a queue-based reference model.
module tb_button_code_capture;

    localparam int WIDTH          = 4;
    localparam int INDEX_WIDTH    = 2;
    localparam int DIGITS         = 4;
    localparam int COUNT_WIDTH    = 3;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int CODE_W         = DIGITS * INDEX_WIDTH;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [WIDTH-1:0]         buttonEdge;
    logic [CODE_W-1:0]        code;
    logic                     codeValid;
    logic [COUNT_WIDTH-1:0]   digitCount;
    logic                     entryError;
    logic                     entryTimeout;

    int checks = 0;
    int errors = 0;

    // Reference model state: digits of the partial entry, current code, strobes.
    int m_q[$];
    int m_code  = 0;
    int m_idle  = 0;
    bit m_valid = 0;
    bit m_err   = 0;
    bit m_to    = 0;

    always #5 clock = ~clock;

    button_code_capture #(
        .WIDTH(WIDTH), .INDEX_WIDTH(INDEX_WIDTH), .DIGITS(DIGITS),
        .COUNT_WIDTH(COUNT_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock(clock), .reset(reset), .buttonEdge(buttonEdge), .code(code),
        .codeValid(codeValid), .digitCount(digitCount), .entryError(entryError),
        .entryTimeout(entryTimeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: one call per clock edge with the inputs that edge sampled.
    task automatic model_step(input logic [WIDTH-1:0] e, input logic r);
        int ones;
        int idx;
        m_valid = 0; m_err = 0; m_to = 0;
        if (r) begin
            m_q.delete(); m_code = 0; m_idle = 0;
            return;
        end
        ones = $countones(e);
        if (ones > 1) begin
            m_q.delete(); m_code = 0; m_err = 1; m_idle = 0;
        end else if (ones == 1) begin
            idx = 0;
            for (int i = 0; i < WIDTH; i++) if (e[i]) idx = i;
            if (m_q.size() == 0) m_code = 0;
            m_q.push_back(idx);
            m_code = (m_code * (1 << INDEX_WIDTH) + idx) % (1 << CODE_W);
            m_idle = 0;
            if (m_q.size() == DIGITS) begin
                m_valid = 1;
                m_q.delete();
            end
        end else if (m_q.size() > 0) begin
            m_idle++;
`ifdef INACTIVITY_TIMEOUT_EN
            if (m_idle == TIMEOUT_CYCLES) begin
                m_to = 1; m_q.delete(); m_code = 0; m_idle = 0;
            end
`endif
        end
    endtask

    // Apply one cycle of stimulus, then compare every output with the model.
    task automatic step(input logic [WIDTH-1:0] e, input logic r, input string tag);
        buttonEdge = e;
        reset      = r;
        @(posedge clock);
        #1;
        model_step(e, r);
        check({tag, ".code"},         32'(code),         32'(m_code));
        check({tag, ".digitCount"},   32'(digitCount),   32'(m_q.size()));
        check({tag, ".codeValid"},    32'(codeValid),    32'(m_valid));
        check({tag, ".entryError"},   32'(entryError),   32'(m_err));
        check({tag, ".entryTimeout"}, 32'(entryTimeout), 32'(m_to));
    endtask

    initial begin
        logic [WIDTH-1:0] e;
        int r;
        buttonEdge = '0;
        reset      = 1'b1;

        // Reset for two cycles, with a press on the second that must be ignored.
        step(4'b0000, 1'b1, "rst0");
        step(4'b0001, 1'b1, "rst1");
        check("rst.code_const", 32'(code), 32'h00);
        check("rst.count_const", 32'(digitCount), 32'd0);

        // Four single presses with idle gaps -> code 8'h1B.
        step(4'b0001, 1'b0, "seq.p1");
        check("seq.count1", 32'(digitCount), 32'd1);
        step(4'b0000, 1'b0, "seq.i1");
        step(4'b0010, 1'b0, "seq.p2");
        step(4'b0000, 1'b0, "seq.i2");
        step(4'b0100, 1'b0, "seq.p3");
        check("seq.count3", 32'(digitCount), 32'd3);
        step(4'b0000, 1'b0, "seq.i3");
        step(4'b1000, 1'b0, "seq.p4");
        check("seq.code_1B", 32'(code), 32'h1B);
        check("seq.valid", 32'(codeValid), 32'd1);
        step(4'b0000, 1'b0, "seq.hold");
        check("seq.hold_1B", 32'(code), 32'h1B);
        check("seq.valid_drop", 32'(codeValid), 32'd0);

        // Multi-button press aborts the entry.
        step(4'b1000, 1'b0, "err.p1");
        step(4'b0100, 1'b0, "err.p2");
        step(4'b0011, 1'b0, "err.multi");
        check("err.strobe", 32'(entryError), 32'd1);
        check("err.code0", 32'(code), 32'h00);
        step(4'b0000, 1'b0, "err.after");

        // Reset mid-entry, then four presses of button 3 -> 8'hFF.
        step(4'b0010, 1'b0, "mid.p1");
        step(4'b0010, 1'b0, "mid.p2");
        step(4'b0000, 1'b1, "mid.rst");
        check("mid.count0", 32'(digitCount), 32'd0);
        step(4'b1000, 1'b0, "ff.p1");
        step(4'b1000, 1'b0, "ff.p2");
        step(4'b1000, 1'b0, "ff.p3");
        step(4'b1000, 1'b0, "ff.p4");
        check("ff.code_FF", 32'(code), 32'hFF);
        check("ff.valid", 32'(codeValid), 32'd1);
        step(4'b0000, 1'b0, "ff.after");

`ifdef INACTIVITY_TIMEOUT_EN
        // Partial entry expires after TIMEOUT_CYCLES idle cycles.
        step(4'b0100, 1'b0, "to.p1");
        for (int i = 1; i < TIMEOUT_CYCLES; i++) step(4'b0000, 1'b0, "to.idle");
        check("to.pre_strobe", 32'(entryTimeout), 32'd0);
        step(4'b0000, 1'b0, "to.expire");
        check("to.strobe", 32'(entryTimeout), 32'd1);
        check("to.code0", 32'(code), 32'h00);
        step(4'b0000, 1'b0, "to.after");
        // Second press on idle cycle 7 keeps the entry alive.
        step(4'b0100, 1'b0, "to7.p1");
        for (int i = 1; i < 7; i++) step(4'b0000, 1'b0, "to7.idle");
        step(4'b0001, 1'b0, "to7.p2");
        check("to7.count2", 32'(digitCount), 32'd2);
        check("to7.no_strobe", 32'(entryTimeout), 32'd0);
        step(4'b0000, 1'b1, "to7.rst");
        // Press exactly on the expiry cycle wins over the timeout.
        step(4'b0100, 1'b0, "to8.p1");
        for (int i = 1; i < TIMEOUT_CYCLES; i++) step(4'b0000, 1'b0, "to8.idle");
        step(4'b0001, 1'b0, "to8.p2");
        check("to8.count2", 32'(digitCount), 32'd2);
        check("to8.no_strobe", 32'(entryTimeout), 32'd0);
        step(4'b0000, 1'b1, "to8.rst");
`else
        // Without the timeout a partial entry is held indefinitely.
        step(4'b0100, 1'b0, "hold.p1");
        for (int i = 0; i < 3 * TIMEOUT_CYCLES; i++) step(4'b0000, 1'b0, "hold.idle");
        check("hold.count1", 32'(digitCount), 32'd1);
        check("hold.no_strobe", 32'(entryTimeout), 32'd0);
        step(4'b0000, 1'b1, "hold.rst");
`endif

        // Held edge counts once per cycle -> four presses of button 0.
        step(4'b0001, 1'b0, "held.c1");
        step(4'b0001, 1'b0, "held.c2");
        step(4'b0001, 1'b0, "held.c3");
        step(4'b0001, 1'b0, "held.c4");
        check("held.code00", 32'(code), 32'h00);
        check("held.valid", 32'(codeValid), 32'd1);
        step(4'b0000, 1'b0, "held.after");
        check("held.valid_once", 32'(codeValid), 32'd0);

        // Random traffic: idle, single presses, multi presses, occasional reset.
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                step(4'(1 << $urandom_range(0, WIDTH - 1)), 1'b1, "rnd.rst");
            end else if (r < 55) begin
                step(4'b0000, 1'b0, "rnd.idle");
            end else if (r < 92) begin
                e = 4'(1 << $urandom_range(0, WIDTH - 1));
                step(e, 1'b0, "rnd.press");
            end else begin
                e = 4'($urandom_range(1, 15));
                step(e, 1'b0, "rnd.any");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
